// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (if_*) and load/store (ls_*).
// One transaction is outstanding at a time. Load/store has priority, and a starvation counter bounds how long fetch waits.
module mem_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                    clk,
   input  logic                    rst_i,
   // instruction-fetch port
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic                    if_gnt,
   output logic                    if_rvalid,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   // load/store port
   input  logic                    ls_req,
   input  logic                    ls_we,
   input  logic [ADDR_WIDTH-1:0]   ls_addr,
   input  logic [DATA_WIDTH-1:0]   ls_wdata,
   input  logic [DATA_WIDTH/8-1:0] ls_be,
   output logic                    ls_gnt,
   output logic                    ls_rvalid,
   output logic [DATA_WIDTH-1:0]   ls_rdata,
   // memory port
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [DATA_WIDTH/8-1:0] mem_be,
   input  logic                    mem_gnt,
   input  logic                    mem_rvalid,
   input  logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    busy
);

   localparam int BE_WIDTH  = DATA_WIDTH / 8;
   localparam int CNT_WIDTH = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_WAIT);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_e;

   state_e                 state_q,    state_d;
   owner_e                 owner_q,    owner_d;
   logic [CNT_WIDTH-1:0]   starve_q,   starve_d;
   logic [ADDR_WIDTH-1:0]  addr_q,     addr_d;
   logic                   we_q,       we_d;
   logic [DATA_WIDTH-1:0]  wdata_q,    wdata_d;
   logic [BE_WIDTH-1:0]    be_q,       be_d;
   logic [DATA_WIDTH-1:0]  if_rdata_q, if_rdata_d;
   logic [DATA_WIDTH-1:0]  ls_rdata_q, ls_rdata_d;

   logic grant_if;
   logic grant_ls;

   // Fetch wins a contested cycle only once load/store has won MAX_WAIT times in a row.
   // Grants are gated with rst_i so that no grant is visible while reset is asserted.
   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (rst_i && (state_q == ST_IDLE)) begin
         if (ls_req && if_req) begin
            if (starve_q == CNT_MAX) grant_if = 1'b1;
            else                     grant_ls = 1'b1;
         end else if (ls_req) begin
            grant_ls = 1'b1;
         end else if (if_req) begin
            grant_if = 1'b1;
         end
      end
   end

   // State register. Every latched field is cleared too, so an aborted transaction leaves nothing on mem_*.
   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         // NOTE: non-blocking assignments keep all registers updating together on the clock edge.
         state_q    <= ST_IDLE;
         owner_q    <= OWN_IF;
         starve_q   <= '0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         be_q       <= '0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         starve_q   <= starve_d;
         addr_q     <= addr_d;
         we_q       <= we_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         if_rdata_q <= if_rdata_d;
         ls_rdata_q <= ls_rdata_d;
      end
   end

   // Next-state and latched-field logic.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      starve_d   = starve_q;
      addr_d     = addr_q;
      we_d       = we_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      if_rdata_d = if_rdata_q;
      ls_rdata_d = ls_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_if) begin
               state_d  = ST_ISSUE;
               owner_d  = OWN_IF;
               addr_d   = if_addr;
               we_d     = 1'b0;
               wdata_d  = '0;
               be_d     = '1;
               starve_d = '0;
            end else if (grant_ls) begin
               state_d = ST_ISSUE;
               owner_d = OWN_LS;
               addr_d  = ls_addr;
               we_d    = ls_we;
               wdata_d = ls_wdata;
               be_d    = ls_be;
               if (if_req && (starve_q != CNT_MAX)) begin
                  starve_d = starve_q + CNT_WIDTH'(1);
               end
            end
         end
         ST_ISSUE: begin
            if (mem_gnt) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rvalid) begin
               state_d = ST_RESP;
               if (owner_q == OWN_LS) ls_rdata_d = mem_rdata;
               else                   if_rdata_d = mem_rdata;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic.
   always_comb begin
      if_gnt    = grant_if;
      ls_gnt    = grant_ls;
      mem_req   = (state_q == ST_ISSUE);
      if_rvalid = (state_q == ST_RESP) && (owner_q == OWN_IF);
      ls_rvalid = (state_q == ST_RESP) && (owner_q == OWN_LS);
      busy      = (state_q != ST_IDLE);
   end

   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_be    = be_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenario tasks, followed by a randomized run.
// The randomized run is checked against a transaction-level timing model.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;
   localparam int MW = 4;

   logic          clk = 1'b0;
   logic          rst_i = 1'b0;
   logic          if_req, if_gnt, if_rvalid;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          ls_req, ls_we, ls_gnt, ls_rvalid;
   logic [AW-1:0] ls_addr;
   logic [DW-1:0] ls_wdata, ls_rdata;
   logic [BW-1:0] ls_be;
   logic          mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [BW-1:0] mem_be;
   logic          busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst_i(rst_i),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
      .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   // Inputs are driven 1 ns after the rising edge. Outputs are sampled 2 ns later, well away from either edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      if_req     = 1'b0;  if_addr  = '0;
      ls_req     = 1'b0;  ls_we    = 1'b0;  ls_addr = '0;  ls_wdata = '0;  ls_be = '0;
      mem_gnt    = 1'b0;  mem_rvalid = 1'b0;  mem_rdata = '0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_i = 1'b0;
      repeat (2) next_cycle();
      rst_i = 1'b1;
      next_cycle();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_i = 1'b0;
      if_req = 1'b1; ls_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      repeat (3) next_cycle();
      settle();
      checks++;
      if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, busy} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got gnt=%b%b rvalid=%b%b mem_req=%b busy=%b required all 0",
                  if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_req, busy);
      end
      checks++;
      if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b0, {BW{1'b0}}, {AW{1'b0}}, {DW{1'b0}}}) begin
         errors++;
         $display("FAIL reset_mem_fields: got we=%b be=%h addr=%h wdata=%h required 0",
                  mem_we, mem_be, mem_addr, mem_wdata);
      end
      checks++;
      if ({if_rdata, ls_rdata} !== {2*DW{1'b0}}) begin
         errors++;
         $display("FAIL reset_rdata: got if=%h ls=%h required 0", if_rdata, ls_rdata);
      end
      idle_inputs();
      next_cycle();
      rst_i = 1'b1;
      next_cycle();
      settle();
      checks++;
      if ({busy, if_gnt, ls_gnt} !== 3'b0) begin
         errors++;
         $display("FAIL post_reset_idle: got busy=%b gnt=%b%b required 0", busy, if_gnt, ls_gnt);
      end
   endtask

   task automatic test_basic_load();
      next_cycle();
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      settle();
      checks++;
      if ({ls_gnt, if_gnt} !== 2'b10) begin
         errors++; $display("FAIL load_gnt_c0: got ls=%b if=%b required ls=1 if=0", ls_gnt, if_gnt);
      end
      next_cycle(); ls_req = 1'b0; settle();
      checks++;
      if ({mem_req, mem_we, mem_addr, busy} !== {1'b1, 1'b0, 32'h100, 1'b1}) begin
         errors++;
         $display("FAIL load_issue_c1: got req=%b we=%b addr=%h busy=%b required 1 0 100 1",
                  mem_req, mem_we, mem_addr, busy);
      end
      next_cycle(); settle();
      checks++;
      if ({mem_req, ls_rvalid} !== 2'b00) begin
         errors++; $display("FAIL load_wait_c2: got req=%b rvalid=%b required 0 0", mem_req, ls_rvalid);
      end
      next_cycle(); settle();
      checks++;
      if ({ls_rvalid, if_rvalid, ls_rdata} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL load_resp_c3: got ls_rvalid=%b if_rvalid=%b rdata=%h required 1 0 deadbeef",
                  ls_rvalid, if_rvalid, ls_rdata);
      end
      next_cycle(); settle();
      checks++;
      if ({ls_rvalid, busy} !== 2'b00) begin
         errors++; $display("FAIL load_done_c4: got rvalid=%b busy=%b required 0 0", ls_rvalid, busy);
      end
      idle_inputs();
   endtask

   task automatic test_fetch_stall();
      next_cycle();
      idle_inputs(); if_req = 1'b1; if_addr = 32'h40;
      settle();
      checks++;
      if ({if_gnt, ls_gnt} !== 2'b10) begin
         errors++; $display("FAIL fetch_gnt: got if=%b ls=%b required if=1 ls=0", if_gnt, ls_gnt);
      end
      for (int i = 0; i < 3; i++) begin
         next_cycle(); if_req = 1'b0; settle();
         checks++;
         if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h40}) begin
            errors++;
            $display("FAIL fetch_stall_%0d: got req=%b we=%b be=%h addr=%h required 1 0 f 40",
                     i, mem_req, mem_we, mem_be, mem_addr);
         end
      end
      next_cycle(); mem_gnt = 1'b1; settle();
      checks++;
      if (mem_req !== 1'b1) begin
         errors++; $display("FAIL fetch_issue_gnt: got mem_req=%b required 1", mem_req);
      end
      next_cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; settle();
      checks++;
      if ({mem_req, if_rvalid} !== 2'b00) begin
         errors++; $display("FAIL fetch_wait: got req=%b rvalid=%b required 0 0", mem_req, if_rvalid);
      end
      next_cycle(); mem_rvalid = 1'b0; settle();
      checks++;
      if ({if_rvalid, ls_rvalid, if_rdata, ls_rdata} !== {1'b1, 1'b0, 32'hCAFE_F00D, 32'hDEAD_BEEF}) begin
         errors++;
         $display("FAIL fetch_resp: got if_rvalid=%b ls_rvalid=%b if_rdata=%h ls_rdata=%h required 1 0 cafef00d deadbeef",
                  if_rvalid, ls_rvalid, if_rdata, ls_rdata);
      end
      next_cycle(); settle();
      checks++;
      if ({if_rvalid, busy} !== 2'b00) begin
         errors++; $display("FAIL fetch_done: got rvalid=%b busy=%b required 0 0", if_rvalid, busy);
      end
      idle_inputs();
   endtask

   task automatic test_starvation();
      bit order [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      int n = 0;
      int budget = 0;
      apply_reset();
      if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h1000; ls_addr = 32'h2000;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0;
      while (n < 10 && budget < 200) begin
         settle();
         if (if_gnt || ls_gnt) begin
            checks++;
            if ((if_gnt && ls_gnt) || (ls_gnt !== order[n])) begin
               errors++;
               $display("FAIL starve_grant_%0d: got ls_gnt=%b if_gnt=%b required ls_gnt=%b",
                        n, ls_gnt, if_gnt, order[n]);
            end
            n++;
         end
         budget++;
         next_cycle();
      end
      checks++;
      if (n != 10) begin
         errors++; $display("FAIL starve_timeout: got %0d grants required 10", n);
      end
      if_req = 1'b0; ls_req = 1'b0;
      repeat (5) next_cycle();
      idle_inputs();
   endtask

   task automatic test_store();
      int ls_pulses = 0;
      int if_pulses = 0;
      next_cycle();
      idle_inputs();
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h1234_5678; ls_be = 4'h3;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_F00D;
      settle();
      checks++;
      if (ls_gnt !== 1'b1) begin
         errors++; $display("FAIL store_gnt: got %b required 1", ls_gnt);
      end
      for (int c = 1; c <= 6; c++) begin
         next_cycle(); ls_req = 1'b0; settle();
         if (ls_rvalid === 1'b1) ls_pulses++;
         if (if_rvalid === 1'b1) if_pulses++;
         if (c == 1) begin
            checks++;
            if ({mem_req, mem_we, mem_wdata, mem_be, mem_addr} !== {1'b1, 1'b1, 32'h1234_5678, 4'h3, 32'h200}) begin
               errors++;
               $display("FAIL store_issue: got req=%b we=%b wdata=%h be=%h addr=%h required 1 1 12345678 3 200",
                        mem_req, mem_we, mem_wdata, mem_be, mem_addr);
            end
         end
         if (c == 3) begin
            checks++;
            if ({ls_rvalid, ls_rdata} !== {1'b1, 32'h0BAD_F00D}) begin
               errors++;
               $display("FAIL store_resp: got rvalid=%b rdata=%h required 1 0badf00d", ls_rvalid, ls_rdata);
            end
         end
      end
      checks++;
      if (ls_pulses != 1 || if_pulses != 0) begin
         errors++;
         $display("FAIL store_pulses: got ls=%0d if=%0d required ls=1 if=0", ls_pulses, if_pulses);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_wait();
      next_cycle();
      idle_inputs(); ls_req = 1'b1; ls_addr = 32'h300; mem_gnt = 1'b1;
      settle();
      checks++;
      if (ls_gnt !== 1'b1) begin
         errors++; $display("FAIL abort_gnt: got %b required 1", ls_gnt);
      end
      next_cycle(); ls_req = 1'b0; settle();
      next_cycle(); mem_gnt = 1'b0; settle();
      checks++;
      if ({busy, mem_req} !== 2'b10) begin
         errors++; $display("FAIL abort_in_wait: got busy=%b req=%b required 1 0", busy, mem_req);
      end
      #1 rst_i = 1'b0;
      #1;
      checks++;
      if ({busy, mem_req, ls_rdata, if_rdata} !== {2'b00, {2*DW{1'b0}}}) begin
         errors++;
         $display("FAIL abort_reset: got busy=%b req=%b ls_rdata=%h if_rdata=%h required 0",
                  busy, mem_req, ls_rdata, if_rdata);
      end
      next_cycle(); rst_i = 1'b1;
      next_cycle(); mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555; if_req = 1'b1; if_addr = 32'h80;
      settle();
      checks++;
      if ({ls_rvalid, if_rvalid, busy} !== 3'b000) begin
         errors++;
         $display("FAIL late_rvalid: got ls_rvalid=%b if_rvalid=%b busy=%b required 0 0 0", ls_rvalid, if_rvalid, busy);
      end
      checks++;
      if ({if_gnt, ls_gnt} !== 2'b10) begin
         errors++; $display("FAIL abort_next_gnt: got if=%b ls=%b required if=1 ls=0", if_gnt, ls_gnt);
      end
      next_cycle(); if_req = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b1; settle();
      checks++;
      if ({mem_req, mem_addr, ls_rvalid, if_rvalid} !== {1'b1, 32'h80, 2'b00}) begin
         errors++;
         $display("FAIL abort_next_issue: got req=%b addr=%h rvalid=%b%b required 1 80 00",
                  mem_req, mem_addr, ls_rvalid, if_rvalid);
      end
      next_cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h6666_6666; settle();
      next_cycle(); mem_rvalid = 1'b0; settle();
      checks++;
      if ({if_rvalid, ls_rvalid, if_rdata, ls_rdata} !== {2'b10, 32'h6666_6666, 32'h0}) begin
         errors++;
         $display("FAIL abort_next_resp: got if_rvalid=%b ls_rvalid=%b if_rdata=%h ls_rdata=%h required 1 0 66666666 0",
                  if_rvalid, ls_rvalid, if_rdata, ls_rdata);
      end
      idle_inputs();
   endtask

   task automatic test_early_rvalid();
      int pulses = 0;
      next_cycle();
      idle_inputs(); ls_req = 1'b1; ls_addr = 32'h3A0;
      settle();
      checks++;
      if (ls_gnt !== 1'b1) begin
         errors++; $display("FAIL early_gnt: got %b required 1", ls_gnt);
      end
      next_cycle(); ls_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111; settle();
      pulses += int'(ls_rvalid === 1'b1) + int'(if_rvalid === 1'b1);
      next_cycle(); mem_gnt = 1'b1; mem_rdata = 32'h2222_2222; settle();
      pulses += int'(ls_rvalid === 1'b1) + int'(if_rvalid === 1'b1);
      checks++;
      if (mem_req !== 1'b1) begin
         errors++; $display("FAIL early_still_issue: got mem_req=%b required 1", mem_req);
      end
      next_cycle(); mem_gnt = 1'b0; mem_rvalid = 1'b0; settle();
      pulses += int'(ls_rvalid === 1'b1) + int'(if_rvalid === 1'b1);
      checks++;
      if ({mem_req, busy} !== 2'b01) begin
         errors++; $display("FAIL early_wait: got req=%b busy=%b required 0 1", mem_req, busy);
      end
      next_cycle(); mem_rvalid = 1'b1; mem_rdata = 32'h3333_3333; settle();
      pulses += int'(ls_rvalid === 1'b1) + int'(if_rvalid === 1'b1);
      next_cycle(); mem_rvalid = 1'b0; mem_rdata = '0; settle();
      pulses += int'(ls_rvalid === 1'b1) + int'(if_rvalid === 1'b1);
      checks++;
      if ({ls_rvalid, ls_rdata} !== {1'b1, 32'h3333_3333}) begin
         errors++; $display("FAIL early_resp: got rvalid=%b rdata=%h required 1 33333333", ls_rvalid, ls_rdata);
      end
      repeat (2) begin
         next_cycle(); settle();
         pulses += int'(ls_rvalid === 1'b1) + int'(if_rvalid === 1'b1);
      end
      checks++;
      if (pulses != 1) begin
         errors++; $display("FAIL early_pulse_count: got %0d required 1", pulses);
      end
      idle_inputs();
   endtask

   // Transaction-level model. A grant at cycle g, with d_g stall cycles and d_r response delay, yields:
   // mem_req on [g+1, g+1+d_g], mem_rvalid at the end of [g+2+d_g, +d_r], the owner's rvalid one cycle later,
   // and the next grant possible one cycle after that.
   task automatic test_random(input int n_cycles);
      bit            if_pend = 1'b0, ls_pend = 1'b0, exp_if_g, exp_ls_g, own_ls = 1'b0;
      logic [AW-1:0] r_if_addr = '0, r_ls_addr = '0, t_addr = '0;
      logic [DW-1:0] r_ls_wdata = '0, t_wdata = '0, resp_data = '0;
      logic [DW-1:0] exp_if_rdata = '0, exp_ls_rdata = '0;
      logic [BW-1:0] r_ls_be = '0, t_be = '0;
      bit            r_ls_we = 1'b0, t_we = 1'b0;
      int            starve = 0, free_at = 0, gnt_c = -10, iss_lo = -10, iss_hi = -10;
      int            wt_lo = -10, wt_hi = -10, resp_c = -10, dg, dr;
      bit            in_iss, in_wait;
      apply_reset();
      for (int cyc = 0; cyc < n_cycles; cyc++) begin
         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1'b1; r_if_addr = $urandom;
         end
         if (!ls_pend && $urandom_range(0, 2) == 0) begin
            ls_pend = 1'b1; r_ls_we = 1'($urandom_range(0, 1)); r_ls_addr = $urandom;
            r_ls_wdata = $urandom; r_ls_be = BW'($urandom_range(0, 15));
         end
         if_req   = if_pend;
         if_addr  = if_pend ? r_if_addr : AW'($urandom);
         ls_req   = ls_pend;
         ls_we    = ls_pend ? r_ls_we : 1'($urandom_range(0, 1));
         ls_addr  = ls_pend ? r_ls_addr : AW'($urandom);
         ls_wdata = ls_pend ? r_ls_wdata : DW'($urandom);
         ls_be    = ls_pend ? r_ls_be : BW'($urandom_range(0, 15));

         exp_if_g = 1'b0; exp_ls_g = 1'b0;
         if (cyc >= free_at) begin
            if (ls_pend && if_pend) begin
               if (starve == MW) exp_if_g = 1'b1;
               else              exp_ls_g = 1'b1;
            end else if (ls_pend) exp_ls_g = 1'b1;
            else if (if_pend)     exp_if_g = 1'b1;
         end

         in_iss  = (cyc >= iss_lo) && (cyc <= iss_hi);
         in_wait = (cyc >= wt_lo) && (cyc <= wt_hi);
         mem_gnt    = in_iss ? (cyc == iss_hi) : 1'($urandom_range(0, 1));
         mem_rvalid = in_wait ? (cyc == wt_hi) : ($urandom_range(0, 3) == 0);
         mem_rdata  = (cyc == wt_hi) ? resp_data : DW'($urandom);
         if (cyc == resp_c) begin
            if (own_ls) exp_ls_rdata = resp_data;
            else        exp_if_rdata = resp_data;
         end
         settle();

         checks++;
         if ({if_gnt, ls_gnt} !== {exp_if_g, exp_ls_g}) begin
            errors++;
            $display("FAIL rnd_gnt @%0d: got if=%b ls=%b required if=%b ls=%b", cyc, if_gnt, ls_gnt, exp_if_g, exp_ls_g);
         end
         checks++;
         if ({mem_req, busy} !== {in_iss, (cyc > gnt_c) && (cyc <= resp_c)}) begin
            errors++;
            $display("FAIL rnd_req_busy @%0d: got req=%b busy=%b required req=%b busy=%b",
                     cyc, mem_req, busy, in_iss, (cyc > gnt_c) && (cyc <= resp_c));
         end
         if (in_iss) begin
            checks++;
            if ({mem_we, mem_be, mem_addr} !== {t_we, t_be, t_addr} || (own_ls && mem_wdata !== t_wdata)) begin
               errors++;
               $display("FAIL rnd_fields @%0d: got we=%b be=%h addr=%h wdata=%h required we=%b be=%h addr=%h wdata=%h",
                        cyc, mem_we, mem_be, mem_addr, mem_wdata, t_we, t_be, t_addr, t_wdata);
            end
         end
         checks++;
         if ({if_rvalid, ls_rvalid} !== {(cyc == resp_c) && !own_ls, (cyc == resp_c) && own_ls}) begin
            errors++;
            $display("FAIL rnd_rvalid @%0d: got if=%b ls=%b required if=%b ls=%b", cyc, if_rvalid, ls_rvalid,
                     (cyc == resp_c) && !own_ls, (cyc == resp_c) && own_ls);
         end
         checks++;
         if ({if_rdata, ls_rdata} !== {exp_if_rdata, exp_ls_rdata}) begin
            errors++;
            $display("FAIL rnd_rdata @%0d: got if=%h ls=%h required if=%h ls=%h", cyc, if_rdata, ls_rdata,
                     exp_if_rdata, exp_ls_rdata);
         end

         if (exp_if_g || exp_ls_g) begin
            if (exp_if_g) begin
               starve = 0; own_ls = 1'b0; t_addr = r_if_addr; t_we = 1'b0; t_be = '1; t_wdata = '0;
               if_pend = 1'b0;
            end else begin
               if (if_pend) starve = (starve < MW) ? starve + 1 : MW;
               own_ls = 1'b1; t_addr = r_ls_addr; t_we = r_ls_we; t_be = r_ls_be; t_wdata = r_ls_wdata;
               ls_pend = 1'b0;
            end
            dg = $urandom_range(0, 3);
            dr = $urandom_range(0, 3);
            gnt_c  = cyc;
            iss_lo = cyc + 1;
            iss_hi = cyc + 1 + dg;
            wt_lo  = cyc + 2 + dg;
            wt_hi  = wt_lo + dr;
            resp_c = wt_hi + 1;
            free_at = resp_c + 1;
            resp_data = $urandom;
         end
         next_cycle();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_basic_load();
      test_fetch_stall();
      test_starvation();
      test_store();
      test_reset_mid_wait();
      test_early_rvalid();
      test_random(1500);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one single-port memory between two requesters: the instruction-fetch port (if_*) and the load/store port (ls_*).
- Sits between the core's fetch/execute stages and the shared memory. One transaction is outstanding at a time.
- Load/store has fixed priority over fetch, and a starvation counter bounds how long fetch can wait.
- Every transaction runs as accept, issue to memory, wait for response, then return the response to the requester that owns it.

Parameters:
- ADDR_WIDTH, 32: address width on all ports.
- DATA_WIDTH, 32: data width on all ports. Byte-enable width is DATA_WIDTH/8.
- MAX_WAIT, 4: number of consecutive load/store grants that may win while if_req is high before fetch is forced to win.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_gnt.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  fetch request accepted (combinational, IDLE only).
- if_rvalid  out  1  one-cycle pulse: fetch data valid.
- if_rdata  out  DATA_WIDTH  fetch read data.
- ls_req  in  1  load/store request; held high until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_WIDTH  load/store address.
- ls_wdata  in  DATA_WIDTH  store data.
- ls_be  in  DATA_WIDTH/8  store byte enables.
- ls_gnt  out  1  load/store request accepted (combinational, IDLE only).
- ls_rvalid  out  1  one-cycle pulse: load data valid, or store complete.
- ls_rdata  out  DATA_WIDTH  load read data.
- mem_req  out  1  memory request; held until mem_gnt.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_be  out  DATA_WIDTH/8  memory byte enables.
- mem_gnt  in  1  memory accepted the request.
- mem_rvalid  in  1  memory response valid.
- mem_rdata  in  DATA_WIDTH  memory read data.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- States are IDLE, ISSUE, WAIT, RESP. Reset (rst_i low, asynchronous) forces:
  - state = IDLE, owner = 0, starve_cnt = 0;
  - all registered outputs and latched fields = 0;
  - every *_gnt, *_rvalid, mem_req and busy low.
- IDLE arbitration (combinational):
  - ls_req only: grant ls.
  - if_req only: grant if.
  - both high: grant if when starve_cnt == MAX_WAIT, otherwise grant ls.
  - Exactly one *_gnt is high in the cycle of acceptance.
  - On the edge that ends that cycle: latch owner, address, we, wdata and be, then go to ISSUE.
  - Fetch transactions latch we = 0 and be = all ones.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) on an ls grant while if_req is high.
  - Clears on any if grant.
  - Unchanged otherwise.
- ISSUE:
  - mem_req = 1 with the latched fields stable.
  - Stay in ISSUE until mem_gnt, then go to WAIT.
  - mem_rvalid in ISSUE is ignored.
- WAIT: mem_req = 0. On mem_rvalid, register mem_rdata into the owner's rdata and go to RESP.
- RESP:
  - The owner's rvalid = 1 for exactly one cycle, then IDLE.
  - A store still produces an ls_rvalid completion pulse; ls_rdata then carries whatever memory returned.
- New requests are never granted outside IDLE.
- rdata outputs hold their last value until the next response.
- Minimum latency, with mem_gnt in the first ISSUE cycle and mem_rvalid in the first WAIT cycle:
  - gnt at cycle 0, mem_req at cycle 1, response captured at cycle 2, rvalid at cycle 3.
  - The next grant is possible at cycle 4.
- Reset mid-transaction aborts it. A late mem_rvalid arriving after reset (state IDLE) is discarded and produces no rvalid.
- busy = (state != IDLE).

Test Plan:
- Reset → all outputs 0 and busy = 0. Then ls_req=1, ls_we=0, ls_addr=0x100, mem_gnt=1, mem_rdata=0xDEADBEEF → ls_gnt at cycle 0, mem_req at 1, ls_rvalid with 0xDEADBEEF at 3, busy low at 4.
- if_req=1 at 0x40; hold mem_gnt low for 3 cycles → mem_req held 3 cycles with mem_addr=0x40, mem_be=0xF, mem_we=0; if_rvalid fires 2 cycles after mem_gnt.
- ls_req and if_req both held high continuously, MAX_WAIT=4 → grant order ls, ls, ls, ls, if, ls, ls, ls, ls, if.
- Store: ls_we=1, ls_wdata=0x12345678, ls_be=0x3 → mem_we=1, mem_wdata=0x12345678, mem_be=0x3 while mem_req is high; ls_rvalid pulses once; if_rvalid stays 0.
- rst_i low during WAIT, then mem_rvalid=1 one cycle after rst_i is released → no *_rvalid pulse, busy=0, next if_req granted immediately.
- mem_rvalid=1 during ISSUE, before mem_gnt → ignored. A proper mem_rvalid after mem_gnt → exactly one rvalid pulse carrying the later mem_rdata.
